udp_frame_filter: RTL and testbench
===================================

Name: udp_frame_filter

Overview:
- Stage 2 of the receive path: consumes the Ethernet byte stream (FCS already stripped) from the RMII deserializer.
- Validates the Ethernet/IPv4/UDP headers against the FPGA addresses and strips them.
- Buffers the UDP payload store-and-forward in a commit/rollback FIFO, so a frame flagged bad at its end (CRC/header error) is never emitted.
- Feeds the ITCH message parser with clean, per-datagram AXI-Stream payload.

Parameters:
- FPGA_MAC, 48'he86a64e7e830, accepted destination MAC (broadcast FF..FF also accepted).
- FPGA_IP, 32'hC0A80164, accepted IPv4 destination address.
- FPGA_PORT, 16'h4567, accepted UDP destination port.
- CHECK_DESTINATION, 1, 1 = enforce MAC/IP/port match; 0 = skip those three checks.
- FIFO_AW, 11, payload FIFO address width (2^FIFO_AW entries, 9 bits each: data + last).

Ports:
- i_rmii_clk  in  1  single clock, 50 MHz.
- i_rstn  in  1  asynchronous active-low reset.
- i_axis_tdata  in  8  frame byte (dst MAC first).
- i_axis_tvalid  in  1  byte valid.
- o_axis_tready  out  1  always 1 after reset; no backpressure upstream.
- i_axis_tlast  in  1  end of frame; may arrive with tvalid=0 as a data-less end marker.
- i_axis_tuser  in  4  bit0 = frame error, sampled on the tlast cycle.
- o_axis_tdata  out  8  payload byte.
- o_axis_tvalid  out  1  payload valid.
- i_axis_tready  in  1  downstream ready.
- o_axis_tlast  out  1  last payload byte of the datagram.
- o_drop  out  1  one-cycle pulse when a frame is discarded.
- o_drop_reason  out  3  reason code, valid with o_drop, otherwise 0.

Behaviour:
- Reset (asynchronous, i_rstn=0): FSM=IDLE, all FIFO pointers=0, o_axis_tvalid=0, o_axis_tlast=0, o_axis_tdata=0, o_drop=0, o_drop_reason=0, o_axis_tready=0. o_axis_tready goes to 1 on the first clock after reset release.
- Input beat rule: a byte is consumed when i_axis_tvalid=1. If the same cycle has tlast=1, the byte is processed first, then end-of-frame is handled.
- Byte index hdr_cnt is 6 bits and saturates at 42.
- Header layout:
  - bytes 0-5: dst MAC.
  - 12-13: ethertype, must be 0x0800.
  - 14: must be 0x45.
  - 23: protocol, must be 0x11.
  - 30-33: dst IP.
  - 36-37: dst port.
  - 38-39: UDP length (UL).
  - bytes 40-41 are ignored; no checksum check.
- States:
  - IDLE: first valid byte -> HDR (index 0).
  - HDR: each field is checked on its final byte. Any mismatch -> DROP with reason latched. After byte 41, check UL>=9, else DROP(6). Then set pay_rem = UL-8 (16 bits) -> PAYLOAD.
  - PAYLOAD: write {last, byte} at wr_ptr and decrement pay_rem. last=1 when pay_rem==1; that byte -> PAD.
  - PAD: discard Ethernet padding until tlast.
  - DROP: discard until tlast.
  - tlast arriving in IDLE is ignored.
- End of frame (tlast):
  - tuser[0]=1 -> reason 1.
  - In HDR or PAYLOAD (truncated) -> reason 6.
  - In PAD with no error -> commit: wr_commit <= wr_ptr.
  - Any drop -> rollback: wr_ptr <= wr_commit; pulse o_drop with the reason. Drop is decided on the tlast cycle.
  - Next state is IDLE.
- Reason codes:
  - 1 upstream frame error
  - 2 MAC mismatch
  - 3 not IPv4/UDP (ethertype, 0x45, or protocol)
  - 4 IP mismatch
  - 5 port mismatch
  - 6 length/truncation
  - 7 FIFO overflow
- Overflow: a write when wr_ptr+1 == rd_ptr sets the overflow flag and stops further writes. The frame ends as DROP(7) and is rolled back. The FSM continues to the state it would otherwise reach.
- Pointers: FIFO_AW+1 bits with wrap bit. The read side only sees data up to wr_commit. Empty when rd_ptr == wr_commit.
- Output: standard AXI-Stream; data, last and valid are held stable while valid=1 and ready=0. First payload byte is on the output within 2 cycles after the commit cycle (RAM read + output register). Full throughput of 1 byte/cycle when ready=1.
- Simultaneous events:
  - Commit and read in the same cycle are legal.
  - A rollback never moves rd_ptr.
  - A new frame may start the cycle after tlast.

Decomposition:
- Shared package udp_rx_pkg:
  - header byte offsets (ETH_TYPE_OFS=12, IP_VIHL_OFS=14, IP_PROTO_OFS=23, IP_DST_OFS=30, UDP_DPORT_OFS=36, UDP_LEN_OFS=38, HDR_LEN=42)
  - ETHERTYPE_IPV4, IP_PROTO_UDP
  - drop reason codes 1-7
  - FSM state encoding
- Sub-module commit_fifo: dual-pointer byte RAM with commit/rollback inputs, registered read, AXI-Stream read side.

Test Plan:
- Valid frame, dst=FPGA_MAC/IP/port 0x4567, UL=0x000C, payload DE AD BE EF, padded to 60 bytes, tuser=0 -> output DE AD BE EF, tlast only on EF, o_drop never pulses.
- Same frame with tuser[0]=1 on tlast -> no output bytes, o_drop=1 for 1 cycle, reason=1, FIFO empty afterwards.
- dst port 0x4568 (CHECK_DESTINATION=1) -> drop, reason 5. Rerun with CHECK_DESTINATION=0 -> payload is delivered.
- Byte 23 = 0x06 (TCP) -> drop, reason 3. An immediately following good frame is delivered intact.
- FIFO_AW=4, i_axis_tready=0, 12-byte payload sent twice -> first frame committed, second dropped with reason 7. With ready=1 only the first 12 bytes appear.
- Assert i_rstn low mid-PAYLOAD -> all outputs 0 asynchronously. Next good frame after release is delivered correctly.

Source files
------------

// File: rtl/udp_rx_pkg.sv
// ---------------------------------------------------------------------------
// udp_rx_pkg
// Shared definitions for the Ethernet/IPv4/UDP receive filter: header byte
// offsets, protocol constants, drop reason codes and the filter FSM states.
// No ports (package).
// ---------------------------------------------------------------------------
package udp_rx_pkg;

    // Header byte offsets counted from the first destination MAC byte
    localparam logic [5:0] ETH_DST_OFS   = 6'd0;
    localparam logic [5:0] ETH_TYPE_OFS  = 6'd12;
    localparam logic [5:0] IP_VIHL_OFS   = 6'd14;
    localparam logic [5:0] IP_PROTO_OFS  = 6'd23;
    localparam logic [5:0] IP_DST_OFS    = 6'd30;
    localparam logic [5:0] UDP_DPORT_OFS = 6'd36;
    localparam logic [5:0] UDP_LEN_OFS   = 6'd38;
    localparam logic [5:0] HDR_LEN       = 6'd42;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VIHL_V4     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_HDR_BYTES  = 16'd8;

    typedef enum logic [2:0] {
        DROP_NONE     = 3'd0,
        DROP_UPSTREAM = 3'd1,
        DROP_MAC      = 3'd2,
        DROP_PROTO    = 3'd3,
        DROP_IP       = 3'd4,
        DROP_PORT     = 3'd5,
        DROP_LEN      = 3'd6,
        DROP_OVERFLOW = 3'd7
    } drop_reason_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_PAD,
        ST_DROP
    } rx_state_t;

    // Header byte index saturates at HDR_LEN
    function automatic logic [5:0] hdr_cnt_inc(input logic [5:0] cnt);
        return (cnt >= HDR_LEN) ? HDR_LEN : cnt + 6'd1;
    endfunction

endpackage

// File: rtl/udp_frame_filter_commit_fifo.sv
// ---------------------------------------------------------------------------
// commit_fifo
// Store-and-forward byte FIFO with commit/rollback on the write side and an
// AXI-Stream read side. Entries are {last, data}. The reader only sees data up
// to the committed write pointer; a rollback rewinds the write pointer to the
// last commit and never touches the read pointer.
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_wr_en, i_wr_data   write one {last, byte} entry at the write pointer
//   i_commit             publish everything written so far (incl. this cycle)
//   i_rollback           discard everything written since the last commit
//   o_full               next write would hit the read pointer
//   o_tdata/o_tvalid/o_tlast, i_tready   AXI-Stream output
// ---------------------------------------------------------------------------
module commit_fifo #(
    parameter int unsigned AW = 11
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_wr_en,
    input  logic [8:0] i_wr_data,
    input  logic       i_commit,
    input  logic       i_rollback,
    output logic       o_full,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    output logic       o_tlast,
    input  logic       i_tready
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [8:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_wr_commit;
    logic [AW:0] r_rd_ptr;
    logic [8:0]  r_rd_data;
    logic        r_s1_valid;
    logic [7:0]  r_out_data;
    logic        r_out_last;
    logic        r_out_valid;

    logic [AW:0] w_wr_ptr_inc;
    logic        w_empty;
    logic        w_out_ready;
    logic        w_s1_free;
    logic        w_rd_en;

    assign w_wr_ptr_inc = r_wr_ptr + PTR_ONE;
    // One slot is kept free so a full ring never aliases the read region
    assign o_full       = (w_wr_ptr_inc[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty      = (r_rd_ptr == r_wr_commit);

    // Two-stage read pipe: RAM read register (s1) then output register.
    // Each stage advances whenever the stage after it can take data.
    assign w_out_ready  = !r_out_valid || i_tready;
    assign w_s1_free    = !r_s1_valid || w_out_ready;
    assign w_rd_en      = !w_empty && w_s1_free;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (i_rollback) begin
                r_wr_ptr <= r_wr_commit;
            end else if (i_wr_en) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end

            // A commit on the same cycle as a write includes that byte
            if (i_commit) begin
                r_wr_commit <= i_wr_en ? w_wr_ptr_inc : r_wr_ptr;
            end

            if (w_rd_en) begin
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                r_s1_valid <= 1'b1;
            end else if (w_out_ready) begin
                r_s1_valid <= 1'b0;
            end

            if (w_out_ready) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_last <= r_rd_data[8];
                    r_out_data <= r_rd_data[7:0];
                end
            end
        end
    end

    assign o_tdata  = r_out_data;
    assign o_tvalid = r_out_valid;
    assign o_tlast  = r_out_last;

endmodule

// File: rtl/udp_frame_filter.sv
// ---------------------------------------------------------------------------
// udp_frame_filter
// Receive-path filter: checks Ethernet/IPv4/UDP headers of the incoming byte
// stream against the FPGA addresses, strips them, and buffers the UDP payload
// in a commit/rollback FIFO so frames flagged bad at their end never appear
// on the output.
// Ports:
//   i_rmii_clk, i_rstn             clock, asynchronous active-low reset
//   i_axis_tdata/tvalid/tlast/tuser  Ethernet byte stream in (tuser[0]=error)
//   o_axis_tready                  1 after reset, no upstream backpressure
//   o_axis_tdata/tvalid/tlast, i_axis_tready   UDP payload stream out
//   o_drop, o_drop_reason          one-cycle pulse + code when a frame is dropped
// ---------------------------------------------------------------------------
module udp_frame_filter
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC          = 48'he86a64e7e830,
    parameter logic [31:0] FPGA_IP           = 32'hC0A80164,
    parameter logic [15:0] FPGA_PORT         = 16'h4567,
    parameter bit          CHECK_DESTINATION = 1'b1,
    parameter int unsigned FIFO_AW           = 11
) (
    input  logic       i_rmii_clk,
    input  logic       i_rstn,
    input  logic [7:0] i_axis_tdata,
    input  logic       i_axis_tvalid,
    output logic       o_axis_tready,
    input  logic       i_axis_tlast,
    input  logic [3:0] i_axis_tuser,
    output logic [7:0] o_axis_tdata,
    output logic       o_axis_tvalid,
    input  logic       i_axis_tready,
    output logic       o_axis_tlast,
    output logic       o_drop,
    output logic [2:0] o_drop_reason
);

    rx_state_t    r_state, w_state_nxt;
    logic [5:0]   r_hdr_cnt, w_hdr_cnt_nxt, w_idx;
    logic [39:0]  r_shift, w_shift_nxt;
    logic [15:0]  r_ul, w_ul_nxt;
    logic [15:0]  r_pay_rem, w_pay_rem_nxt;
    drop_reason_t r_reason, w_reason_nxt;
    logic         r_ovf, w_ovf_nxt;
    logic         r_drop, w_drop_nxt;
    logic [2:0]   r_drop_reason;
    drop_reason_t w_drop_reason_nxt;
    logic         r_tready;

    logic         w_wr_en;
    logic         w_wr_last;
    logic         w_commit;
    logic         w_rollback;
    logic         w_full;
    logic [47:0]  w_mac;
    logic [31:0]  w_word32;
    logic [15:0]  w_word16;
    logic         w_unused_tuser;

    assign w_unused_tuser = ^i_axis_tuser[3:1];

    // Multi-byte fields are compared on their final byte, with the earlier
    // bytes taken from the shift register
    assign w_mac    = {r_shift, i_axis_tdata};
    assign w_word32 = {r_shift[23:0], i_axis_tdata};
    assign w_word16 = {r_shift[7:0], i_axis_tdata};

    always_comb begin
        w_state_nxt       = r_state;
        w_hdr_cnt_nxt     = r_hdr_cnt;
        w_shift_nxt       = r_shift;
        w_ul_nxt          = r_ul;
        w_pay_rem_nxt     = r_pay_rem;
        w_reason_nxt      = r_reason;
        w_ovf_nxt         = r_ovf;
        w_drop_nxt        = 1'b0;
        w_drop_reason_nxt = DROP_NONE;
        w_wr_en           = 1'b0;
        w_wr_last         = 1'b0;
        w_commit          = 1'b0;
        w_rollback        = 1'b0;
        // The byte that leaves IDLE is header byte 0
        w_idx             = (r_state == ST_IDLE) ? ETH_DST_OFS : r_hdr_cnt;

        if (i_axis_tvalid) begin
            w_shift_nxt   = {r_shift[31:0], i_axis_tdata};
            w_hdr_cnt_nxt = hdr_cnt_inc(w_idx);
            case (r_state)
                ST_IDLE, ST_HDR: begin
                    w_state_nxt = ST_HDR;
                    case (w_idx)
                        ETH_DST_OFS + 6'd5: begin
                            if (CHECK_DESTINATION && (w_mac != FPGA_MAC) && (w_mac != '1)) begin
                                w_state_nxt  = ST_DROP;
                                w_reason_nxt = DROP_MAC;
                            end
                        end
                        ETH_TYPE_OFS + 6'd1: begin
                            if (w_word16 != ETHERTYPE_IPV4) begin
                                w_state_nxt  = ST_DROP;
                                w_reason_nxt = DROP_PROTO;
                            end
                        end
                        IP_VIHL_OFS: begin
                            if (i_axis_tdata != IP_VIHL_V4) begin
                                w_state_nxt  = ST_DROP;
                                w_reason_nxt = DROP_PROTO;
                            end
                        end
                        IP_PROTO_OFS: begin
                            if (i_axis_tdata != IP_PROTO_UDP) begin
                                w_state_nxt  = ST_DROP;
                                w_reason_nxt = DROP_PROTO;
                            end
                        end
                        IP_DST_OFS + 6'd3: begin
                            if (CHECK_DESTINATION && (w_word32 != FPGA_IP)) begin
                                w_state_nxt  = ST_DROP;
                                w_reason_nxt = DROP_IP;
                            end
                        end
                        UDP_DPORT_OFS + 6'd1: begin
                            if (CHECK_DESTINATION && (w_word16 != FPGA_PORT)) begin
                                w_state_nxt  = ST_DROP;
                                w_reason_nxt = DROP_PORT;
                            end
                        end
                        UDP_LEN_OFS + 6'd1: begin
                            w_ul_nxt = w_word16;
                        end
                        HDR_LEN - 6'd1: begin
                            // A UDP length below 9 carries no payload byte
                            if (r_ul < (UDP_HDR_BYTES + 16'd1)) begin
                                w_state_nxt  = ST_DROP;
                                w_reason_nxt = DROP_LEN;
                            end else begin
                                w_pay_rem_nxt = r_ul - UDP_HDR_BYTES;
                                w_state_nxt   = ST_PAYLOAD;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_PAYLOAD: begin
                    w_wr_last     = (r_pay_rem == 16'd1);
                    // Once overflowed, the rest of the frame is discarded
                    if (r_ovf || w_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                    w_pay_rem_nxt = r_pay_rem - 16'd1;
                    if (w_wr_last) begin
                        w_state_nxt = ST_PAD;
                    end
                end
                default: ;
            endcase
        end

        // End of frame is judged on the state reached after this cycle's byte
        if (i_axis_tlast && (w_state_nxt != ST_IDLE)) begin
            if (i_axis_tuser[0]) begin
                w_drop_reason_nxt = DROP_UPSTREAM;
            end else if (w_state_nxt == ST_DROP) begin
                w_drop_reason_nxt = w_reason_nxt;
            end else if (w_ovf_nxt) begin
                w_drop_reason_nxt = DROP_OVERFLOW;
            end else if ((w_state_nxt == ST_HDR) || (w_state_nxt == ST_PAYLOAD)) begin
                w_drop_reason_nxt = DROP_LEN;
            end

            if (w_drop_reason_nxt != DROP_NONE) begin
                w_rollback = 1'b1;
                w_drop_nxt = 1'b1;
            end else begin
                w_commit = 1'b1;
            end

            w_state_nxt   = ST_IDLE;
            w_hdr_cnt_nxt = '0;
            w_reason_nxt  = DROP_NONE;
            w_ovf_nxt     = 1'b0;
        end
    end

    always_ff @(posedge i_rmii_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state       <= ST_IDLE;
            r_hdr_cnt     <= '0;
            r_shift       <= '0;
            r_ul          <= '0;
            r_pay_rem     <= '0;
            r_reason      <= DROP_NONE;
            r_ovf         <= 1'b0;
            r_drop        <= 1'b0;
            r_drop_reason <= '0;
            r_tready      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hdr_cnt     <= w_hdr_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_ul          <= w_ul_nxt;
            r_pay_rem     <= w_pay_rem_nxt;
            r_reason      <= w_reason_nxt;
            r_ovf         <= w_ovf_nxt;
            r_drop        <= w_drop_nxt;
            r_drop_reason <= w_drop_reason_nxt;
            r_tready      <= 1'b1;
        end
    end

    commit_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk      (i_rmii_clk),
        .i_rstn     (i_rstn),
        .i_wr_en    (w_wr_en),
        .i_wr_data  ({w_wr_last, i_axis_tdata}),
        .i_commit   (w_commit),
        .i_rollback (w_rollback),
        .o_full     (w_full),
        .o_tdata    (o_axis_tdata),
        .o_tvalid   (o_axis_tvalid),
        .o_tlast    (o_axis_tlast),
        .i_tready   (i_axis_tready)
    );

    assign o_axis_tready = r_tready;
    assign o_drop        = r_drop;
    assign o_drop_reason = r_drop_reason;

endmodule

// File: tb/tb_udp_frame_filter.sv
// ---------------------------------------------------------------------------
// tb_udp_frame_filter
// Directed bench for udp_frame_filter. Three instances share the input
// stream: default parameters (m_), destination checks disabled (n_), and a
// 16-entry FIFO (s_) with its own downstream ready.
// ---------------------------------------------------------------------------
module tb_udp_frame_filter;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tdata = '0;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic [3:0] tuser = '0;
    logic       tready_m = 1'b1;
    logic       tready_s = 1'b1;

    logic [7:0] m_tdata, n_tdata, s_tdata;
    logic       m_tvalid, n_tvalid, s_tvalid;
    logic       m_tlast, n_tlast, s_tlast;
    logic       m_drop, s_drop, n_drop_unused;
    logic [2:0] m_reason, s_reason, n_reason_unused;
    logic       m_tready, n_tready_unused, s_tready_unused;

    int errors = 0;
    int checks = 0;

    logic [7:0] frm [0:127];
    int         frm_len;
    logic [7:0] pay [0:15];

    logic [8:0] q_m [$];
    logic [8:0] q_n [$];
    logic [8:0] q_s [$];
    logic [2:0] d_m [$];
    logic [2:0] d_s [$];

    always #10 clk = ~clk;

    udp_frame_filter dut_m (
        .i_rmii_clk(clk), .i_rstn(rstn),
        .i_axis_tdata(tdata), .i_axis_tvalid(tvalid), .o_axis_tready(m_tready),
        .i_axis_tlast(tlast), .i_axis_tuser(tuser),
        .o_axis_tdata(m_tdata), .o_axis_tvalid(m_tvalid), .i_axis_tready(tready_m),
        .o_axis_tlast(m_tlast), .o_drop(m_drop), .o_drop_reason(m_reason)
    );

    udp_frame_filter #(.CHECK_DESTINATION(1'b0)) dut_n (
        .i_rmii_clk(clk), .i_rstn(rstn),
        .i_axis_tdata(tdata), .i_axis_tvalid(tvalid), .o_axis_tready(n_tready_unused),
        .i_axis_tlast(tlast), .i_axis_tuser(tuser),
        .o_axis_tdata(n_tdata), .o_axis_tvalid(n_tvalid), .i_axis_tready(1'b1),
        .o_axis_tlast(n_tlast), .o_drop(n_drop_unused), .o_drop_reason(n_reason_unused)
    );

    udp_frame_filter #(.FIFO_AW(4)) dut_s (
        .i_rmii_clk(clk), .i_rstn(rstn),
        .i_axis_tdata(tdata), .i_axis_tvalid(tvalid), .o_axis_tready(s_tready_unused),
        .i_axis_tlast(tlast), .i_axis_tuser(tuser),
        .o_axis_tdata(s_tdata), .o_axis_tvalid(s_tvalid), .i_axis_tready(tready_s),
        .o_axis_tlast(s_tlast), .o_drop(s_drop), .o_drop_reason(s_reason)
    );

    // Record accepted output beats and drop pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (m_tvalid && tready_m) q_m.push_back({m_tlast, m_tdata});
        if (n_tvalid)             q_n.push_back({n_tlast, n_tdata});
        if (s_tvalid && tready_s) q_s.push_back({s_tlast, s_tdata});
        if (m_drop) d_m.push_back(m_reason);
        if (s_drop) d_s.push_back(s_reason);
    end

    task automatic clear_q();
        q_m.delete(); q_n.delete(); q_s.delete(); d_m.delete(); d_s.delete();
    endtask

    task automatic build(input logic [15:0] dport, input logic [7:0] proto, input int npay);
        logic [47:0] mac;
        logic [15:0] ul;
        logic [15:0] iplen;
        mac   = 48'he86a64e7e830;
        ul    = 16'(npay + 8);
        iplen = ul + 16'd20;
        frm_len = (42 + npay < 60) ? 60 : 42 + npay;
        for (int i = 0; i < 128; i++) frm[i] = 8'h00;
        for (int i = 0; i < 6; i++) frm[i] = mac[47 - 8*i -: 8];
        frm[6] = 8'h02; frm[11] = 8'h01;
        frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45;
        frm[16] = iplen[15:8]; frm[17] = iplen[7:0];
        frm[22] = 8'h40; frm[23] = proto;
        frm[26] = 8'hC0; frm[27] = 8'hA8; frm[28] = 8'h01; frm[29] = 8'h0A;
        frm[30] = 8'hC0; frm[31] = 8'hA8; frm[32] = 8'h01; frm[33] = 8'h64;
        frm[34] = 8'h12; frm[35] = 8'h34;
        frm[36] = dport[15:8]; frm[37] = dport[7:0];
        frm[38] = ul[15:8]; frm[39] = ul[7:0];
        for (int i = 0; i < npay; i++) frm[42 + i] = pay[i];
    endtask

    task automatic send(input bit err);
        for (int i = 0; i < frm_len; i++) begin
            @(posedge clk); #1;
            tdata  = frm[i];
            tvalid = 1'b1;
            tlast  = (i == frm_len - 1);
            tuser  = (err && (i == frm_len - 1)) ? 4'b0001 : 4'b0000;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0; tuser = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_deadbeef();
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
        checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got=%h exp=00", m_tdata); end
        checks++; if (m_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", m_drop); end
        checks++; if (m_reason !== 3'd0) begin errors++; $display("FAIL reset_reason got=%0d exp=0", m_reason); end
        checks++; if (m_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b exp=0", m_tready); end
        rstn = 1'b1;
        #1;
        checks++; if (m_tready !== 1'b0) begin errors++; $display("FAIL tready_before_edge got=%b exp=0", m_tready); end
        @(negedge clk);
        checks++; if (m_tready !== 1'b1) begin errors++; $display("FAIL tready_after_edge got=%b exp=1", m_tready); end
    endtask

    task automatic test_good_frame();
        logic [8:0] exp;
        set_deadbeef();
        build(16'h4567, 8'h11, 4);
        clear_q();
        send(1'b0);
        idle(25);
        checks++; if (q_m.size() !== 4) begin errors++; $display("FAIL good_count got=%0d exp=4", q_m.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = {(i == 3), pay[i]};
            checks++;
            if (i >= q_m.size() || q_m[i] !== exp) begin
                errors++; $display("FAIL good_byte%0d got=%h exp=%h", i, (i < q_m.size()) ? q_m[i] : 9'h1FF, exp);
            end
        end
        checks++; if (d_m.size() !== 0) begin errors++; $display("FAIL good_drops got=%0d exp=0", d_m.size()); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL good_drained got=%b exp=0", m_tvalid); end
    endtask

    task automatic test_upstream_error();
        set_deadbeef();
        build(16'h4567, 8'h11, 4);
        clear_q();
        send(1'b1);
        idle(25);
        checks++; if (q_m.size() !== 0) begin errors++; $display("FAIL err_output got=%0d exp=0", q_m.size()); end
        checks++; if (d_m.size() !== 1) begin errors++; $display("FAIL err_pulse_cycles got=%0d exp=1", d_m.size()); end
        checks++; if (d_m.size() == 0 || d_m[0] !== 3'd1) begin errors++; $display("FAIL err_reason got=%0d exp=1", (d_m.size() > 0) ? d_m[0] : 3'd0); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL err_fifo_empty got=%b exp=0", m_tvalid); end
    endtask

    task automatic test_port_mismatch();
        logic [8:0] exp;
        set_deadbeef();
        build(16'h4568, 8'h11, 4);
        clear_q();
        send(1'b0);
        idle(25);
        checks++; if (q_m.size() !== 0) begin errors++; $display("FAIL port_output got=%0d exp=0", q_m.size()); end
        checks++; if (d_m.size() == 0 || d_m[0] !== 3'd5) begin errors++; $display("FAIL port_reason got=%0d exp=5", (d_m.size() > 0) ? d_m[0] : 3'd0); end
        checks++; if (q_n.size() !== 4) begin errors++; $display("FAIL nocheck_count got=%0d exp=4", q_n.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = {(i == 3), pay[i]};
            checks++;
            if (i >= q_n.size() || q_n[i] !== exp) begin
                errors++; $display("FAIL nocheck_byte%0d got=%h exp=%h", i, (i < q_n.size()) ? q_n[i] : 9'h1FF, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        set_deadbeef();
        build(16'h4567, 8'h06, 4);
        clear_q();
        send(1'b0);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        build(16'h4567, 8'h11, 4);
        send(1'b0);
        idle(25);
        checks++; if (d_m.size() !== 1) begin errors++; $display("FAIL b2b_drops got=%0d exp=1", d_m.size()); end
        checks++; if (d_m.size() == 0 || d_m[0] !== 3'd3) begin errors++; $display("FAIL b2b_reason got=%0d exp=3", (d_m.size() > 0) ? d_m[0] : 3'd0); end
        checks++; if (q_m.size() !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", q_m.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = {(i == 3), pay[i]};
            checks++;
            if (i >= q_m.size() || q_m[i] !== exp) begin
                errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, (i < q_m.size()) ? q_m[i] : 9'h1FF, exp);
            end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] exp;
        tready_s = 1'b0;
        for (int i = 0; i < 12; i++) pay[i] = 8'(8'h30 + i);
        build(16'h4567, 8'h11, 12);
        clear_q();
        send(1'b0);
        for (int i = 0; i < 12; i++) pay[i] = 8'(8'h50 + i);
        build(16'h4567, 8'h11, 12);
        send(1'b0);
        idle(40);
        checks++; if (d_s.size() !== 1) begin errors++; $display("FAIL ovf_drops got=%0d exp=1", d_s.size()); end
        checks++; if (d_s.size() == 0 || d_s[0] !== 3'd7) begin errors++; $display("FAIL ovf_reason got=%0d exp=7", (d_s.size() > 0) ? d_s[0] : 3'd0); end
        checks++; if (s_tvalid !== 1'b1 || s_tdata !== 8'h30) begin errors++; $display("FAIL ovf_hold got=%b/%h exp=1/30", s_tvalid, s_tdata); end
        checks++; if (d_m.size() !== 0) begin errors++; $display("FAIL ovf_main_drops got=%0d exp=0", d_m.size()); end
        tready_s = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (q_s.size() !== 12) begin errors++; $display("FAIL ovf_count got=%0d exp=12", q_s.size()); end
        for (int i = 0; i < 12; i++) begin
            exp = {(i == 11), 8'(8'h30 + i)};
            checks++;
            if (i >= q_s.size() || q_s[i] !== exp) begin
                errors++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, (i < q_s.size()) ? q_s[i] : 9'h1FF, exp);
            end
        end
    endtask

    task automatic test_reset_mid_payload();
        logic [8:0] exp;
        tready_s = 1'b0;
        set_deadbeef();
        build(16'h4567, 8'h11, 4);
        send(1'b0);
        idle(10);
        for (int i = 0; i < 4; i++) pay[i] = 8'(8'h61 + i);
        build(16'h4567, 8'h11, 4);
        for (int i = 0; i <= 44; i++) begin
            @(posedge clk); #1;
            tdata = frm[i]; tvalid = 1'b1; tlast = 1'b0; tuser = '0;
        end
        #5;
        rstn = 1'b0;
        #1;
        checks++; if (s_tvalid !== 1'b0 || s_tdata !== 8'h00 || s_tlast !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got=%b/%h/%b exp=0/00/0", s_tvalid, s_tdata, s_tlast); end
        checks++; if (m_tready !== 1'b0) begin errors++; $display("FAIL midrst_tready got=%b exp=0", m_tready); end
        checks++; if (m_drop !== 1'b0 || m_reason !== 3'd0) begin errors++; $display("FAIL midrst_drop got=%b/%0d exp=0/0", m_drop, m_reason); end
        tvalid = 1'b0;
        tready_s = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) pay[i] = 8'(8'h71 + i);
        build(16'h4567, 8'h11, 4);
        clear_q();
        send(1'b0);
        idle(25);
        checks++; if (q_m.size() !== 4) begin errors++; $display("FAIL postrst_count got=%0d exp=4", q_m.size()); end
        checks++; if (q_s.size() !== 4) begin errors++; $display("FAIL postrst_small_count got=%0d exp=4", q_s.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = {(i == 3), pay[i]};
            checks++;
            if (i >= q_m.size() || q_m[i] !== exp) begin
                errors++; $display("FAIL postrst_byte%0d got=%h exp=%h", i, (i < q_m.size()) ? q_m[i] : 9'h1FF, exp);
            end
            checks++;
            if (i >= q_s.size() || q_s[i] !== exp) begin
                errors++; $display("FAIL postrst_small_byte%0d got=%h exp=%h", i, (i < q_s.size()) ? q_s[i] : 9'h1FF, exp);
            end
        end
        checks++; if (d_m.size() !== 0) begin errors++; $display("FAIL postrst_drops got=%0d exp=0", d_m.size()); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_upstream_error();
        test_port_mismatch();
        test_back_to_back();
        test_overflow();
        test_reset_mid_payload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
